alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 8-bit combinational alu (fun/Rx/Ry -> Result/band) between N_REQ requesters.
//  Round-robin arbitration; operands latched and held stable while the alu evaluates.
//  Result and band are registered, then returned with a one-cycle ack to the granted requester.
//  Sits between the control unit / peripheral masters and the alu instance in the microprocessor top.
// PARAMETERS
//  N_REQ   2  number of requesters (>=2)
//  DATA_W  8  operand/result width; matches alu Rx/Ry/Result
//  FUN_W   3  function-select width; matches alu fun
//  BAND_W  3  flag width; matches alu band
// PORTS
//  clk         in   1             rising-edge clock
//  rst         in   1             asynchronous, active-high reset
//  req         in   N_REQ         per-requester request, level
//  fun_in      in   N_REQ*FUN_W   packed fun; slice i belongs to req[i]
//  rx_in       in   N_REQ*DATA_W  packed Rx operands
//  ry_in       in   N_REQ*DATA_W  packed Ry operands
//  ack         out  N_REQ         one-hot, one-cycle completion pulse
//  result_out  out  DATA_W        registered Result; valid while ack!=0, held otherwise
//  band_out    out  BAND_W        registered band; same timing as result_out
//  busy        out  1             high in EXEC and RESP
//  alu_fun     out  FUN_W         to alu fun
//  alu_rx      out  DATA_W        to alu Rx
//  alu_ry      out  DATA_W        to alu Ry
//  alu_result  in   DATA_W        from alu Result
//  alu_band    in   BAND_W        from alu band
//  op_count    out  16            completed operations, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async): state=IDLE, ptr=0, ack=0, result_out=0, band_out=0, latched fun/rx/ry=0, op_count=0, busy=0.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: if |req at edge k: grant lowest-index i >= ptr with req[i]; if none, wrap to lowest i < ptr.
//         Latch gnt_id, fun_in[i], rx_in[i], ry_in[i]; go EXEC. If req==0, stay IDLE.
//   EXEC: alu_* driven from latched registers only; they never change in this state.
//         At edge k+1: result_out<=alu_result, band_out<=alu_band, ack[gnt_id]<=1; go RESP.
//   RESP: ack high for exactly this cycle. At edge k+2: ack<=0, ptr<=(gnt_id+1) mod N_REQ,
//         op_count<=op_count+1 unless at max; go IDLE. req is not sampled in RESP.
//  Latency: req sampled at edge k -> ack visible after edge k+1 for one cycle.
//  Throughput: one operation per 3 cycles.
//  Requester protocol: hold req and operands until ack is seen.
//   req still high in the next IDLE cycle is treated as a new request.
//   Operand changes after the latch edge have no effect.
//  Boundaries:
//   - req withdrawn during EXEC/RESP: operation still completes; ack still pulses.
//   - simultaneous requests: round-robin from ptr. No requester waits more than N_REQ-1 grants.
//   - ptr wraps N_REQ-1 -> 0.
//   - op_count holds at 16'hFFFF.
//   - rst mid-EXEC/RESP: operation aborted, no ack, all state to reset values immediately.
//   - alu_* outputs are latched copies; in IDLE they show the last granted operands (0 after reset).
// STRUCTURE
//  alu_pkg: DATA_W/FUN_W/BAND_W defaults, state encoding localparams (IDLE=2'd0, EXEC=2'd1,
//   RESP=2'd2), fun code localparams shared with alu and the control unit.
//  Sub-module rr_pick: combinational round-robin selector (req, ptr -> gnt_id, any).
//  FSM, operand latches, result regs and counter stay in alu_arbiter.
//  Top level instantiates alu_arbiter + alu side by side.
// TESTING (bench instantiates alu_arbiter + real alu; golden values from a second, direct alu instance)
//  1. req[0]=1, fun=3'b000, Rx=8'h01, Ry=8'hFF -> ack=2'b01 one cycle, 2 edges after sampling;
//     result_out/band_out == direct alu(000,01,FF); busy high 2 cycles.
//  2. After reset, req=2'b11 held (operands differ per port) -> ack order 0,1,0,1;
//     gaps exactly 3 cycles; op_count=4 after 4 acks.
//  3. Sweep fun 000..111 on requester 1 (Rx=01, Ry=FF) -> each result/band matches direct alu;
//     ptr wrap verified.
//  4. req[1] pulsed for one cycle only, then dropped during EXEC -> ack[1] still pulses once.
//     Changing rx_in in EXEC leaves alu_rx unchanged.
//  5. Assert rst during EXEC -> ack never asserted, busy=0, result_out=0, op_count unchanged from 0.
//  6. Preload op_count near max (force or 65535 ops) -> stays 16'hFFFF on the next ack.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the alu arbiter: default widths, FSM encoding,
// alu function codes and band flag positions.
package alu_arbiter_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_FUN_W  = 3;
    localparam int DEF_BAND_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Function codes understood by the alu and issued by the control unit.
    localparam logic [DEF_FUN_W-1:0] FUN_ADD = 3'b000;
    localparam logic [DEF_FUN_W-1:0] FUN_SUB = 3'b001;
    localparam logic [DEF_FUN_W-1:0] FUN_AND = 3'b010;
    localparam logic [DEF_FUN_W-1:0] FUN_OR  = 3'b011;
    localparam logic [DEF_FUN_W-1:0] FUN_XOR = 3'b100;
    localparam logic [DEF_FUN_W-1:0] FUN_NOT = 3'b101;
    localparam logic [DEF_FUN_W-1:0] FUN_SHL = 3'b110;
    localparam logic [DEF_FUN_W-1:0] FUN_SHR = 3'b111;

    // Bit positions inside band: {carry/borrow, zero, negative}.
    localparam int BAND_C = 2;
    localparam int BAND_Z = 1;
    localparam int BAND_N = 0;

    localparam logic [15:0] OP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin selector: lowest requester at or above ptr,
// otherwise wraps to the lowest requester below ptr.
module alu_arbiter_rr_pick #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] gnt_id,
    output logic             any
);

    logic [PTR_W-1:0] gnt_hi;
    logic [PTR_W-1:0] gnt_lo;
    logic             found_hi;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        gnt_hi   = '0;
        gnt_lo   = '0;
        found_hi = 1'b0;
        // Descending scan: the last hit written is the lowest index.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_lo = PTR_W'(i);
                if (i >= int'(ptr)) begin
                    gnt_hi   = PTR_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        gnt_id = found_hi ? gnt_hi : gnt_lo;
        any    = |req;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational alu between N_REQ requesters:
// latch operands, let the alu settle for a cycle, register and return the result.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FUN_W  = DEF_FUN_W,
    parameter int BAND_W = DEF_BAND_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*FUN_W-1:0]    fun_in,
    input  logic [N_REQ*DATA_W-1:0]   rx_in,
    input  logic [N_REQ*DATA_W-1:0]   ry_in,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         result_out,
    output logic [BAND_W-1:0]         band_out,
    output logic                      busy,
    output logic [FUN_W-1:0]          alu_fun,
    output logic [DATA_W-1:0]         alu_rx,
    output logic [DATA_W-1:0]         alu_ry,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic [BAND_W-1:0]         alu_band,
    output logic [15:0]               op_count
);

    localparam int PTR_W = $clog2(N_REQ);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic [FUN_W-1:0]   fun_q, fun_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  ry_q, ry_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [BAND_W-1:0]  band_q, band_d;
    logic [15:0]        op_count_q, op_count_d;

    logic [PTR_W-1:0]   pick_id;
    logic               pick_any;

    alu_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        fun_d      = fun_q;
        rx_d       = rx_q;
        ry_d       = ry_q;
        ack_d      = '0;
        result_d   = result_q;
        band_d     = band_q;
        op_count_d = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_id;
                    fun_d   = fun_in[int'(pick_id)*FUN_W +: FUN_W];
                    rx_d    = rx_in[int'(pick_id)*DATA_W +: DATA_W];
                    ry_d    = ry_in[int'(pick_id)*DATA_W +: DATA_W];
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d       = alu_result;
                band_d         = alu_band;
                ack_d[gnt_q]   = 1'b1;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                ptr_d      = (gnt_q == PTR_W'(N_REQ - 1)) ? '0 : gnt_q + PTR_W'(1);
                op_count_d = (op_count_q != OP_CNT_MAX) ? op_count_q + 16'd1 : op_count_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: operand latches are reset too, so the alu sees all-zero inputs after reset.
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            fun_q      <= '0;
            rx_q       <= '0;
            ry_q       <= '0;
            ack_q      <= '0;
            result_q   <= '0;
            band_q     <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            fun_q      <= fun_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            ack_q      <= ack_d;
            result_q   <= result_d;
            band_q     <= band_d;
            op_count_q <= op_count_d;
        end
    end

    assign ack        = ack_q;
    assign result_out = result_q;
    assign band_out   = band_q;
    assign busy       = (state_q != ST_IDLE);
    assign alu_fun    = fun_q;
    assign alu_rx     = rx_q;
    assign alu_ry     = ry_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a small behavioural alu on the alu_* side;
// expected results are hand-computed constants pushed when a request is issued.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [5:0]  fun_in = '0;
    logic [15:0] rx_in = '0;
    logic [15:0] ry_in = '0;
    logic [1:0]  ack;
    logic [7:0]  result_out;
    logic [2:0]  band_out;
    logic        busy;
    logic [2:0]  alu_fun;
    logic [7:0]  alu_rx;
    logic [7:0]  alu_ry;
    logic [7:0]  alu_result;
    logic [2:0]  alu_band;
    logic [15:0] op_count;

    alu_arbiter #(
        .N_REQ  (2),
        .DATA_W (8),
        .FUN_W  (3),
        .BAND_W (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .fun_in     (fun_in),
        .rx_in      (rx_in),
        .ry_in      (ry_in),
        .ack        (ack),
        .result_out (result_out),
        .band_out   (band_out),
        .busy       (busy),
        .alu_fun    (alu_fun),
        .alu_rx     (alu_rx),
        .alu_ry     (alu_ry),
        .alu_result (alu_result),
        .alu_band   (alu_band),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // Behavioural alu: band = {carry/borrow, zero, negative}.
    logic [8:0] r9;
    always_comb begin
        r9 = '0;
        case (alu_fun)
            FUN_ADD: r9 = {1'b0, alu_rx} + {1'b0, alu_ry};
            FUN_SUB: r9 = {1'b0, alu_rx} - {1'b0, alu_ry};
            FUN_AND: r9 = {1'b0, alu_rx & alu_ry};
            FUN_OR:  r9 = {1'b0, alu_rx | alu_ry};
            FUN_XOR: r9 = {1'b0, alu_rx ^ alu_ry};
            FUN_NOT: r9 = {1'b0, ~alu_rx};
            FUN_SHL: r9 = {alu_rx, 1'b0};
            FUN_SHR: r9 = {alu_rx[0], 1'b0, alu_rx[7:1]};
            default: r9 = '0;
        endcase
        alu_result = r9[7:0];
        alu_band   = {r9[8], (r9[7:0] == 8'h00), r9[7]};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         id;
        logic [7:0] res;
        logic [2:0] band;
        int         at_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic expect_ack(input int id, input logic [7:0] res, input logic [2:0] band,
                              input int at_cyc);
        exp_t e;
        e.id = id; e.res = res; e.band = band; e.at_cyc = at_cyc;
        sb.push_back(e);
    endtask

    // Monitor: every ack pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && ack != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'b0, ack}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_onehot", {30'b0, ack}, 32'(1) << e.id);
                check("result_out", {24'b0, result_out}, {24'b0, e.res});
                check("band_out", {29'b0, band_out}, {29'b0, e.band});
                check("ack_cycle", cyc, e.at_cyc);
            end
        end
    end

    task automatic set_port(input int p, input logic [2:0] f, input logic [7:0] x,
                            input logic [7:0] y);
        fun_in[p*3 +: 3] = f;
        rx_in[p*8 +: 8]  = x;
        ry_in[p*8 +: 8]  = y;
    endtask

    // Called #1 after a rising edge with the arbiter idle; returns the same way, idle again.
    task automatic issue(input logic [1:0] r, input int id, input logic [7:0] res,
                         input logic [2:0] band);
        expect_ack(id, res, band, cyc + 2);
        req = r;
        @(posedge clk); #1;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] sweep_res  [8] = '{8'h00, 8'h02, 8'h01, 8'hFF, 8'hFE, 8'hFE, 8'h02, 8'h00};
    logic [2:0] sweep_band [8] = '{3'b110, 3'b100, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b110};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset state, with busy-looking inputs that must be ignored.
        req = 2'b11;
        set_port(0, FUN_OR, 8'h5A, 8'hA5);
        set_port(1, FUN_OR, 8'h3C, 8'hC3);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {30'b0, ack}, 32'h0);
        check("rst_result", {24'b0, result_out}, 32'h0);
        check("rst_band", {29'b0, band_out}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_op_count", {16'b0, op_count}, 32'h0);
        check("rst_alu_rx", {24'b0, alu_rx}, 32'h0);
        check("rst_alu_fun", {29'b0, alu_fun}, 32'h0);
        req = '0;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single ADD on requester 0, busy for exactly two cycles.
        set_port(0, FUN_ADD, 8'h01, 8'hFF);
        expect_ack(0, 8'h00, 3'b110, cyc + 2);
        req = 2'b01;
        @(negedge clk); check("t1_busy_c0", {31'b0, busy}, 32'h0);
        @(posedge clk); #1; req = '0;
        @(negedge clk); check("t1_busy_c1", {31'b0, busy}, 32'h1);
        @(negedge clk); check("t1_busy_c2", {31'b0, busy}, 32'h1);
        @(negedge clk); check("t1_busy_c3", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;

        // 4: one-cycle request; operand change after the latch edge is ignored.
        set_port(1, FUN_ADD, 8'h10, 8'h20);
        expect_ack(1, 8'h30, 3'b000, cyc + 2);
        req = 2'b10;
        @(posedge clk); #1;
        req = '0;
        set_port(1, FUN_SUB, 8'hAA, 8'h55);
        @(negedge clk);
        check("t4_alu_rx_held", {24'b0, alu_rx}, 32'h10);
        check("t4_alu_ry_held", {24'b0, alu_ry}, 32'h20);
        check("t4_alu_fun_held", {29'b0, alu_fun}, {29'b0, FUN_ADD});
        repeat (2) @(posedge clk);
        #1;

        // 3: function sweep on requester 1, then ptr wrap (1 -> 0) with both requesting.
        for (int f = 0; f < 8; f++) begin
            set_port(1, 3'(f), 8'h01, 8'hFF);
            issue(2'b10, 1, sweep_res[f], sweep_band[f]);
        end
        check("t3_alu_rx_idle", {24'b0, alu_rx}, 32'h01);
        set_port(0, FUN_ADD, 8'h05, 8'h03);
        set_port(1, FUN_XOR, 8'hFF, 8'h00);
        issue(2'b11, 0, 8'h08, 3'b000);

        // 2: both held after reset: order 0,1,0,1 every 3 cycles.
        do_reset();
        set_port(0, FUN_ADD, 8'h05, 8'h03);
        set_port(1, FUN_SUB, 8'h03, 8'h05);
        c = cyc;
        expect_ack(0, 8'h08, 3'b000, c + 2);
        expect_ack(1, 8'hFE, 3'b101, c + 5);
        expect_ack(0, 8'h08, 3'b000, c + 8);
        expect_ack(1, 8'hFE, 3'b101, c + 11);
        req = 2'b11;
        repeat (12) @(posedge clk);
        #1;
        req = '0;
        check("t2_op_count", {16'b0, op_count}, 32'd4);
        repeat (2) @(posedge clk);
        #1;

        // 5: reset in EXEC aborts the operation.
        do_reset();
        set_port(0, FUN_ADD, 8'h01, 8'h01);
        req = 2'b01;
        @(posedge clk); #1;
        check("t5_busy_exec", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        req = '0;
        #1;
        check("t5_ack", {30'b0, ack}, 32'h0);
        check("t5_busy", {31'b0, busy}, 32'h0);
        check("t5_result", {24'b0, result_out}, 32'h0);
        check("t5_op_count", {16'b0, op_count}, 32'h0);
        check("t5_alu_rx", {24'b0, alu_rx}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t5_no_ack_after", {30'b0, ack}, 32'h0);

        // 6: counter saturation.
        force dut.op_count_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.op_count_q;
        @(posedge clk); #1;
        check("t6_preload", {16'b0, op_count}, 32'hFFFE);
        set_port(0, FUN_OR, 8'h0F, 8'hF0);
        issue(2'b01, 0, 8'hFF, 3'b001);
        check("t6_reach_max", {16'b0, op_count}, 32'hFFFF);
        set_port(1, FUN_AND, 8'hF0, 8'h0F);
        issue(2'b10, 1, 8'h00, 3'b010);
        check("t6_hold_max", {16'b0, op_count}, 32'hFFFF);

        repeat (5) @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
